// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  // Operand width used when the instantiating block does not override it.
  localparam int unsigned DefaultWidth = 8;

  // Controller states: waiting, shifting bits through the cell, presenting the result.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit-counter width: clog2 of the operand width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock through a single full-adder cell,
// LSB first, with a start/done handshake. Latency is WIDTH+1 cycles from start to done.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed-overflow
// output 'ovf'.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned    CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  fa_cell u_fa_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state: accept in IDLE/DONE, shift one bit per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        // start is deliberately ignored here; operands live only in the shift registers.
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on the last bit.
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Outputs are decodes of registered state only; no input-to-output path.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    sum  = sum_sr_q;
    cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operands
// checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W    = 8;
  localparam int          MaxS = (1 <<< (W - 1)) - 1;
  localparam int          MinS = -MaxS - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned sum of width W+1.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int unsigned s;
    s = int'(x) + int'(y) + int'(c);
    return s[W:0];
  endfunction

  // Reference: true signed result out of the W-bit two's-complement range.
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    int sx;
    int sy;
    int s;
    sx = int'($signed(x));
    sy = int'($signed(y));
    s  = sx + sy + int'(c);
    return (s > MaxS) || (s < MinS);
  endfunction

  // Drive start for one edge; returns after the accepting edge (counts as edge 1).
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int n, output logic seen);
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic c);
    logic [W:0] e;
    e = ref_add(x, y, c);
    chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
  endtask

  // Full transaction: latency counted from start assertion, result, one-cycle done.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
    int   n;
    logic seen;
    start_op(x, y, c);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n, seen);
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n + 1), 32'(W + 1));
    check_result(tag, x, y, c);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   n;
    int   m;
    int   cnt;
    logic seen;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rc;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    run_op("basic", 8'h35, 8'h4A, 1'b0);
    chk("basic_sum_const", 32'(sum), 32'h7F);
    run_op("ripple", 8'hFF, 8'h00, 1'b1);
    chk("ripple_cout_const", 32'(cout), 32'd1);
    run_op("sovf", 8'h7F, 8'h01, 1'b0);
    chk("sovf_sum_const", 32'(sum), 32'h80);

    // Result holds through IDLE.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", 32'(sum), 32'h80);

    // start pulsed mid-RUN with different operands must be ignored.
    start_op(8'h10, 8'h20, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, seen);
    chk("ignore_done_seen", 32'(seen), 32'd1);
    chk("ignore_latency", 32'(4 + n), 32'(W + 1));
    chk("ignore_sum", 32'(sum), 32'h30);
    count_dones(20, cnt);
    chk("ignore_single_done", 32'(cnt), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    a     = 8'h0F;
    b     = 8'h01;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'hF0;
    b = 8'h10;
    wait_done(n, seen);
    chk("b2b_first_seen", 32'(seen), 32'd1);
    chk("b2b_first_latency", 32'(n + 1), 32'(W + 1));
    check_result("b2b_first", 8'h0F, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(m, seen);
    chk("b2b_second_seen", 32'(seen), 32'd1);
    chk("b2b_gap", 32'(m + 1), 32'(W + 1));
    check_result("b2b_second", 8'hF0, 8'h10, 1'b0);
    chk("b2b_second_sum_const", 32'(sum), 32'h00);

    // Reset four cycles into RUN aborts without done.
    start_op(8'h55, 8'hAA, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("abort_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    count_dones(20, cnt);
    chk("abort_no_done", 32'(cnt), 32'd0);

    for (int i = 0; i < 24; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rc = 1'($urandom);
      run_op($sformatf("rand%0d", i), rx, ry, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
